// File: rtl/alu_pipe.sv
// Pipelined WIDTH-generic ALU with flags, optional accumulator feedback and a
// STAGES-deep valid/ready output pipeline that stalls as a whole under backpressure.
module alu_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter bit ACC_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             use_acc,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             clr_sticky,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             neg_flag,
    output logic             ovf_flag,
    output logic             sticky_ovf
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] c_res;
    logic             c_carry;
    logic             c_ovf;
    logic             adv;
    logic             accept;

    // Flags per stage are packed as {zero, carry, neg, ovf}.
    logic [WIDTH-1:0] st_res [STAGES];
    logic [3:0]       st_flg [STAGES];
    logic [STAGES-1:0] st_vld;

    always_comb begin
        a_eff   = (ACC_EN && use_acc) ? acc : operand_a;
        sum     = {1'b0, a_eff} + {1'b0, operand_b};
        diff    = {1'b0, a_eff} - {1'b0, operand_b};
        c_res   = '0;
        c_carry = 1'b0;
        c_ovf   = 1'b0;
        case (op)
            3'b000: c_res = a_eff & operand_b;
            3'b001: c_res = a_eff | operand_b;
            3'b010: c_res = a_eff ^ operand_b;
            3'b011: begin
                c_res   = sum[WIDTH-1:0];
                c_carry = sum[WIDTH];
                c_ovf   = (a_eff[WIDTH-1] == operand_b[WIDTH-1]) &&
                          (sum[WIDTH-1] != a_eff[WIDTH-1]);
            end
            3'b100: begin
                c_res   = diff[WIDTH-1:0];
                c_carry = diff[WIDTH];
                c_ovf   = (a_eff[WIDTH-1] != operand_b[WIDTH-1]) &&
                          (diff[WIDTH-1] != a_eff[WIDTH-1]);
            end
            3'b101: c_res = operand_b;
            3'b110: begin
                c_res   = {a_eff[WIDTH-2:0], 1'b0};
                c_carry = a_eff[WIDTH-1];
            end
            default: begin
                c_res   = {1'b0, a_eff[WIDTH-1:1]};
                c_carry = a_eff[0];
            end
        endcase
    end

    // Handshake: a transfer happens on an edge where valid && ready are both 1;
    // in_ready depends only on the output side, so the whole pipe moves or holds.
    assign out_valid = st_vld[STAGES-1];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign accept    = in_valid && adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_vld <= '0;
            for (int i = 0; i < STAGES; i++) begin
                st_res[i] <= '0;
                st_flg[i] <= '0;
            end
        end else if (adv) begin
            st_vld[0] <= accept;
            st_res[0] <= c_res;
            st_flg[0] <= {(c_res == '0), c_carry, c_res[WIDTH-1], c_ovf};
            for (int i = 1; i < STAGES; i++) begin
                st_vld[i] <= st_vld[i-1];
                st_res[i] <= st_res[i-1];
                st_flg[i] <= st_flg[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (ACC_EN && accept) begin
            acc <= c_res;
        end
    end

    // A new overflow outranks a simultaneous clear so no event is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf <= 1'b0;
        end else if (accept && c_ovf) begin
            sticky_ovf <= 1'b1;
        end else if (clr_sticky) begin
            sticky_ovf <= 1'b0;
        end
    end

    assign result     = st_res[STAGES-1];
    assign zero_flag  = st_flg[STAGES-1][3];
    assign carry_flag = st_flg[STAGES-1][2];
    assign neg_flag   = st_flg[STAGES-1][1];
    assign ovf_flag   = st_flg[STAGES-1][0];

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed scenarios with literal expectations plus random
// traffic checked every cycle against an arithmetic reference model.
module tb_alu_pipe;
  localparam int W  = 8;
  localparam int ST = 2;
  localparam bit AE = 1'b1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic         use_acc;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         clr_sticky;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero_flag;
  logic         carry_flag;
  logic         neg_flag;
  logic         ovf_flag;
  logic         sticky_ovf;

  alu_pipe #(.WIDTH(W), .STAGES(ST), .ACC_EN(AE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .use_acc(use_acc), .operand_a(operand_a), .operand_b(operand_b),
    .clr_sticky(clr_sticky), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero_flag(zero_flag), .carry_flag(carry_flag),
    .neg_flag(neg_flag), .ovf_flag(ovf_flag), .sticky_ovf(sticky_ovf)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // scoreboard: {result, zero, carry, neg, ovf}
  logic [W+3:0] exp_q[$];
  logic [W-1:0] out_log[$];
  logic [W-1:0] m_acc = '0;
  logic         m_sticky = 1'b0;
  logic         prev_hold = 1'b0;
  logic [W+4:0] prev_out = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [W+3:0] model(input logic [2:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint full = longint'(1) << W;
    longint half = longint'(1) << (W - 1);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = (ua >= half) ? ua - full : ua;
    longint sb = (ub >= half) ? ub - full : ub;
    longint r = 0;
    longint sr = 0;
    logic c = 1'b0;
    logic v = 1'b0;
    logic [W-1:0] rr;
    case (o)
      3'd0: r = longint'(a & b);
      3'd1: r = longint'(a | b);
      3'd2: r = longint'(a ^ b);
      3'd3: begin
        r = ua + ub; c = (r >= full); sr = sa + sb;
        v = (sr > half - 1) || (sr < -half);
        r = r % full;
      end
      3'd4: begin
        r = ua - ub; c = (ua < ub); sr = sa - sb;
        v = (sr > half - 1) || (sr < -half);
        if (r < 0) r = r + full;
      end
      3'd5: r = ub;
      3'd6: begin r = (ua * 2) % full; c = (ua >= half); end
      default: begin r = ua / 2; c = (ua % 2) == 1; end
    endcase
    rr = r[W-1:0];
    return {rr, (r == 0), c, (r >= half), v};
  endfunction

  // compare process: inputs settle at posedge+1, so at negedge they are the
  // values the next edge will sample, and outputs reflect the last edge
  always @(negedge clk) begin
    if (rst_n) begin
      logic [W+3:0] e;
      logic [W-1:0] a_eff;
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      chk("sticky_ovf", sticky_ovf, m_sticky);
      if (prev_hold)
        chk("stall_hold", {out_valid, result, zero_flag, carry_flag, neg_flag, ovf_flag}, prev_out);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("result_flags", {result, zero_flag, carry_flag, neg_flag, ovf_flag}, e);
          out_log.push_back(result);
        end
      end
      if (in_valid && in_ready) begin
        a_eff = (AE && use_acc) ? m_acc : operand_a;
        e = model(op, a_eff, operand_b);
        exp_q.push_back(e);
        if (AE) m_acc = e[W+3:4];
        if (e[0]) m_sticky = 1'b1;
        else if (clr_sticky) m_sticky = 1'b0;
      end else if (clr_sticky) begin
        m_sticky = 1'b0;
      end
      prev_hold = out_valid && !out_ready;
      prev_out  = {out_valid, result, zero_flag, carry_flag, neg_flag, ovf_flag};
    end
  end

  // driver tasks
  task automatic send(input logic [2:0] o, input logic ua, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic clr);
    int waited = 0;
    in_valid = 1'b1; op = o; use_acc = ua; operand_a = a; operand_b = b; clr_sticky = clr;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 100) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; clr_sticky = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = '0; use_acc = 1'b0; operand_a = '0;
    operand_b = '0; clr_sticky = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {zero_flag, carry_flag, neg_flag, ovf_flag}, 0);
    chk("rst_sticky", sticky_ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // ADD FF+01, latency check
    send(3'd3, 1'b0, 8'hFF, 8'h01, 1'b0);
    chk("add_not_early", out_valid, 0);
    repeat (ST - 1) @(posedge clk); #1;
    chk("add_out_valid", out_valid, 1);
    chk("add_result", result, 8'h00);
    chk("add_flags_zcnv", {zero_flag, carry_flag, neg_flag, ovf_flag}, 4'b1100);
    idle(2);

    // SUB 80-01 and sticky set/clear priority
    send(3'd4, 1'b0, 8'h80, 8'h01, 1'b0);
    chk("sub_sticky_set", sticky_ovf, 1);
    repeat (ST - 1) @(posedge clk); #1;
    chk("sub_result", result, 8'h7F);
    chk("sub_flags_zcnv", {zero_flag, carry_flag, neg_flag, ovf_flag}, 4'b0001);
    send(3'd3, 1'b0, 8'h7F, 8'h01, 1'b1);
    chk("sticky_set_wins", sticky_ovf, 1);
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    chk("sticky_cleared", sticky_ovf, 0);
    idle(4);

    // backpressure: three logic ops against a stalled consumer
    out_log.delete();
    out_ready = 1'b0;
    fork
      begin
        send(3'd0, 1'b0, 8'hF0, 8'h3C, 1'b0);
        send(3'd1, 1'b0, 8'h0F, 8'h30, 1'b0);
        send(3'd2, 1'b0, 8'hAA, 8'hFF, 1'b0);
      end
      begin
        repeat (4) @(posedge clk); #1;
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_result", result, 8'h30);
        out_ready = 1'b1;
      end
    join
    idle(5);
    chk("bp_count", out_log.size(), 3);
    if (out_log.size() == 3) begin
      chk("bp_order0", out_log[0], 8'h30);
      chk("bp_order1", out_log[1], 8'h3F);
      chk("bp_order2", out_log[2], 8'h55);
    end

    // accumulator chain
    out_log.delete();
    send(3'd5, 1'b0, 8'h00, 8'h05, 1'b0);
    send(3'd3, 1'b1, 8'hEE, 8'h03, 1'b0);
    send(3'd6, 1'b1, 8'hEE, 8'h00, 1'b0);
    idle(5);
    chk("acc_count", out_log.size(), 3);
    if (out_log.size() == 3) begin
      chk("acc_chain0", out_log[0], 8'h05);
      chk("acc_chain1", out_log[1], 8'h08);
      chk("acc_chain2", out_log[2], 8'h10);
    end

    // mid-flight reset pulse shorter than half a cycle
    send(3'd1, 1'b0, 8'h11, 8'h22, 1'b0);
    send(3'd2, 1'b0, 8'h0F, 8'h01, 1'b0);
    #1 rst_n = 1'b0;
    exp_q.delete(); m_acc = '0; m_sticky = 1'b0; prev_hold = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_flags", {zero_flag, carry_flag, neg_flag, ovf_flag, sticky_ovf}, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("no_stale_valid", out_valid, 0);
    out_log.delete();
    send(3'd3, 1'b1, 8'h99, 8'h02, 1'b0);
    idle(4);
    chk("post_rst_count", out_log.size(), 1);
    if (out_log.size() == 1) chk("post_rst_acc", out_log[0], 8'h02);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 8'h7F + W'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) rb = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h80;
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 9) < 7);
      clr_sticky = ($urandom_range(0, 9) == 0);
      op         = 3'($urandom_range(0, 7));
      use_acc    = $urandom_range(0, 1) == 1;
      operand_a  = ra;
      operand_b  = rb;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; clr_sticky = 1'b0; out_ready = 1'b1;
    idle(ST + 4);
    chk("drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised successor to the 8-bit AND/OR registered ALU. Adds WIDTH-generic datapath, 8 operations, full flag set, optional accumulator feedback, and a STAGES-deep valid/ready pipeline with backpressure. Sits between operand sources and the result/flag consumer in the datapath. It targets ASAP7 RVT gate-level mapping like its predecessor.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
STAGES, 2, pipeline depth in registers from input acceptance to output (1..4)
ACC_EN, 1, 1 = accumulator and use_acc implemented; 0 = use_acc ignored, acc held at 0

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input transaction valid
in_ready  output  1  block can accept input this cycle
op  input  3  operation code (see Behaviour)
use_acc  input  1  1 = A operand is the accumulator, operand_a ignored
operand_a  input  WIDTH  A operand
operand_b  input  WIDTH  B operand
clr_sticky  input  1  clears sticky_ovf
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts output this cycle
result  output  WIDTH  registered result
zero_flag  output  1  result == 0
carry_flag  output  1  carry/borrow/shifted-out bit
neg_flag  output  1  result MSB
ovf_flag  output  1  signed overflow
sticky_ovf  output  1  set by any issued op with overflow, held until cleared

Behaviour:
- Opcodes: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB (A-B), 101 PASS_B, 110 SHL1 (A<<1), 111 SHR1 (A>>1, logical).
- A_eff = (ACC_EN && use_acc) ? acc : operand_a.
- Arithmetic is WIDTH+1 bits internally. result = low WIDTH bits.
- carry_flag: ADD carry-out; SUB borrow (1 when A_eff < B unsigned); SHL1 A_eff[WIDTH-1]; SHR1 A_eff[0]; else 0.
- ovf_flag: ADD = operands same sign, result sign differs. SUB = operand signs differ, result sign != A_eff sign. Else 0.
- zero_flag and neg_flag are derived from result for every op.
- Compute is combinational from the inputs. It is captured into stage 1 on acceptance; stages 2..STAGES are delay registers carrying result, flags and a valid bit.
- Handshake: adv = !out_valid || out_ready. in_ready = adv.
  - Accept = in_valid && in_ready.
  - When adv=1, all stages shift; stage 1 loads the computed value with valid = accept.
  - When adv=0, all stages hold. The output must not change while out_valid && !out_ready.
  - Bubbles are not collapsed. in_ready depends only on out_valid and out_ready, never on in_valid.
- Latency: an accepted input appears with out_valid=1 exactly STAGES cycles later when there is no backpressure. Throughput is 1 per cycle. Order is preserved.
- Accumulator: acc <= computed result on every accept, at the same edge as stage-1 capture. Back-to-back use_acc ops therefore chain with no hazard. acc is not updated while stalled.
- sticky_ovf:
  - Set on accept when the computed ovf=1.
  - Cleared when clr_sticky=1.
  - If set and clear occur in the same cycle, set wins.
  - It is not gated by the handshake.
- Reset (rst_n=0, asynchronous, at any time including mid-flight):
  - All stage valid bits, result, all flags, acc and sticky_ovf go to 0.
  - in_ready=1 after reset since out_valid=0.
  - In-flight transactions are dropped.
  - Outputs reflect stage STAGES registers only. No combinational path from inputs to result or flags.

Test Plan:
1. Assert rst_n=0, then release -> out_valid=0, result=0x00, all flags 0, sticky_ovf=0, in_ready=1.
2. WIDTH=8, STAGES=2: ADD a=0xFF b=0x01, out_ready=1 -> two cycles later out_valid=1, result=0x00, zero=1, carry=1, ovf=0, neg=0.
3. SUB a=0x80 b=0x01 -> result=0x7F, ovf=1, carry=0, neg=0, sticky_ovf=1. Then clr_sticky=1 with a simultaneous ADD 0x7F+0x01 (ovf) -> sticky_ovf stays 1. Then clr_sticky alone -> 0.
4. Issue AND 0xF0&0x3C, OR 0x0F|0x30, XOR 0xAA^0xFF back-to-back with out_ready=0 -> in_ready falls after the first reaches output. Output holds 0x30 stable. On releasing out_ready, outputs are 0x30, 0x3F, 0x55 in order, no loss or duplication.
5. Accumulator chain: PASS_B b=0x05, then ADD use_acc=1 b=0x03, then SHL1 use_acc=1, issued back-to-back -> results 0x05, 0x08, 0x10.
6. Pulse rst_n low for a partial cycle with 2 transactions in flight -> outputs go to 0 immediately. No stale out_valid after release. A following ADD use_acc=1 b=0x02 gives 0x02 (acc=0).
